// File: rtl/multi_channel_producer_if.sv
// Handshake bundle between multi_channel_producer and the pipeline under test.
// The producer side is "master" and the pipeline side is "slave".
// The optional per-channel stall counters appear only when PRODUCER_STALL_CNT_EN is defined.
interface multi_channel_producer_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32
);
  logic                     enable;
  logic [NUM_CH-1:0]        in_stall;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_flush;
  logic                     out_busy;
`ifdef PRODUCER_STALL_CNT_EN
  logic [NUM_CH*16-1:0]     stall_cnt;

  modport master (
    input  enable, in_stall,
    output out_data, out_valid, out_flush, out_busy, stall_cnt
  );

  modport slave (
    output enable, in_stall,
    input  out_data, out_valid, out_flush, out_busy, stall_cnt
  );
`else
  modport master (
    input  enable, in_stall,
    output out_data, out_valid, out_flush, out_busy
  );

  modport slave (
    output enable, in_stall,
    input  out_data, out_valid, out_flush, out_busy
  );
`endif
endinterface

// File: rtl/multi_channel_producer.sv
// multi_channel_producer: NUM_CH independent incrementing-sequence sources with
// valid/stall handshake and a flush window ahead of every beat whose low
// FLUSH_LOG2 bits equal the channel mark (channel index mod 2**FLUSH_LOG2).
// Optional feature macro: PRODUCER_STALL_CNT_EN adds saturating 16-bit
// per-channel stall-cycle counters on bus.stall_cnt.
module multi_channel_producer #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 32,
  parameter int FLUSH_LOG2 = 8,
  parameter int FLUSH_LEN  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  multi_channel_producer_if.master bus
);

  typedef enum logic [1:0] {IDLE, FLUSH, SEND} state_t;

  // Flush timer counts down from FLUSH_LEN-1 to 0, so the window lasts FLUSH_LEN cycles.
  localparam logic [7:0] TIMER_LOAD = 8'(FLUSH_LEN - 1);

  logic [NUM_CH*DATA_W-1:0] data_all;
  logic [NUM_CH-1:0]        valid_all;
  logic [NUM_CH-1:0]        flush_all;
  logic [NUM_CH-1:0]        busy_all;
`ifdef PRODUCER_STALL_CNT_EN
  logic [NUM_CH*16-1:0]     stall_all;
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam logic [FLUSH_LOG2-1:0] MARK     = FLUSH_LOG2'(gi % (2 ** FLUSH_LOG2));
    localparam logic [DATA_W-1:0]     CNT_INIT = DATA_W'(gi);

    state_t            state_reg;
    logic [7:0]        timer_reg;
    logic [DATA_W-1:0] cnt_reg;
    logic [DATA_W-1:0] cnt_inc;
    logic              valid_reg;
    logic              flush_reg;

    assign cnt_inc = cnt_reg + DATA_W'(1);

    // Channel FSM: IDLE -> FLUSH -> SEND, re-flushing before each mark beat.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_reg <= IDLE;
        timer_reg <= '0;
        cnt_reg   <= CNT_INIT;
        valid_reg <= 1'b0;
        flush_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (bus.enable) begin
              state_reg <= FLUSH;
              flush_reg <= 1'b1;
              timer_reg <= TIMER_LOAD;
            end
          end
          FLUSH: begin
            if (timer_reg == 8'd0) begin
              flush_reg <= 1'b0;
              if (bus.enable) begin
                state_reg <= SEND;
                valid_reg <= 1'b1;
              end else begin
                state_reg <= IDLE;
              end
            end else begin
              timer_reg <= timer_reg - 8'd1;
            end
          end
          SEND: begin
            // A stalled beat is held untouched; enable only matters after a transfer.
            if (!bus.in_stall[gi]) begin
              cnt_reg <= cnt_inc;
              if (cnt_inc[FLUSH_LOG2-1:0] == MARK) begin
                state_reg <= FLUSH;
                valid_reg <= 1'b0;
                flush_reg <= 1'b1;
                timer_reg <= TIMER_LOAD;
              end else if (!bus.enable) begin
                state_reg <= IDLE;
                valid_reg <= 1'b0;
              end
            end
          end
          default: begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
            flush_reg <= 1'b0;
          end
        endcase
      end
    end

    assign data_all[gi*DATA_W +: DATA_W] = cnt_reg;
    assign valid_all[gi]                 = valid_reg;
    assign flush_all[gi]                 = flush_reg;
    assign busy_all[gi]                  = (state_reg != IDLE);

`ifdef PRODUCER_STALL_CNT_EN
    logic [15:0] stall_cnt_reg;

    // Count cycles where a beat is offered but held off, saturating at all-ones.
    always_ff @(posedge clk) begin
      if (reset) begin
        stall_cnt_reg <= '0;
      end else if (valid_reg && bus.in_stall[gi] && (stall_cnt_reg != 16'hFFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
    end

    assign stall_all[gi*16 +: 16] = stall_cnt_reg;
`endif
  end

  assign bus.out_data  = data_all;
  assign bus.out_valid = valid_all;
  assign bus.out_flush = flush_all;
  assign bus.out_busy  = |busy_all;
`ifdef PRODUCER_STALL_CNT_EN
  assign bus.stall_cnt = stall_all;
`endif

endmodule

// File: tb/tb_multi_channel_producer.sv
// Scoreboard bench for multi_channel_producer (default parameters, two channels).
// Expected beats (data plus the flush-window length that must precede them) are
// queued per channel when a run is started and checked as beats transfer.
module tb_multi_channel_producer;

  localparam int NUM_CH     = 2;
  localparam int DATA_W     = 32;
  localparam int FLUSH_LOG2 = 8;
  localparam int FLUSH_LEN  = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  multi_channel_producer_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  multi_channel_producer #(
    .NUM_CH    (NUM_CH),
    .DATA_W    (DATA_W),
    .FLUSH_LOG2(FLUSH_LOG2),
    .FLUSH_LEN (FLUSH_LEN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    int                flush_before;
  } exp_t;

  exp_t              exp_q [NUM_CH][$];
  int                n_checks = 0;
  int                n_fail   = 0;
  int                flush_run [NUM_CH];
  logic              hold [NUM_CH];
  logic [DATA_W-1:0] hold_data [NUM_CH];
  int                stall_done;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] ch_data(input int c);
    return bus.out_data[c*DATA_W +: DATA_W];
  endfunction

  // Queue beats start..stop; the first gets a flush window if the run starts from IDLE,
  // later ones only when their low bits hit the channel mark.
  task automatic push_run(input int c, input int start, input int stop, input bit from_idle);
    exp_t e;
    for (int d = start; d <= stop; d++) begin
      e.data = DATA_W'(d);
      if (d == start) e.flush_before = from_idle ? FLUSH_LEN : 0;
      else e.flush_before = ((d % (1 << FLUSH_LOG2)) == (c % (1 << FLUSH_LOG2))) ? FLUSH_LEN : 0;
      exp_q[c].push_back(e);
    end
  endtask

  task automatic consume(input int c);
    exp_t e;
    logic [DATA_W-1:0] d;
    d = ch_data(c);
    check($sformatf("ch%0d_beat_expected", c), (exp_q[c].size() != 0), 1);
    if (exp_q[c].size() != 0) begin
      e = exp_q[c].pop_front();
      check($sformatf("ch%0d_data", c), d, e.data);
      check($sformatf("ch%0d_flush_len_before_%0d", c, e.data), flush_run[c], e.flush_before);
      $display("ch%0d beat data=%0d flush_cycles_before=%0d", c, d, flush_run[c]);
    end
    flush_run[c] = 0;
  endtask

  // One clock: account beats completing at the coming edge, then sample #1 after it.
  task automatic cycle();
    for (int c = 0; c < NUM_CH; c++) begin
      hold[c]      = !reset && bus.out_valid[c] && bus.in_stall[c];
      hold_data[c] = ch_data(c);
      if (!reset && bus.out_valid[c] && !bus.in_stall[c]) consume(c);
    end
    @(posedge clk);
    #1;
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        flush_run[c] = 0;
        exp_q[c].delete();
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (hold[c]) begin
          check($sformatf("ch%0d_stall_valid_held", c), bus.out_valid[c], 1);
          check($sformatf("ch%0d_stall_data_held", c), ch_data(c), hold_data[c]);
        end
        if (bus.out_flush[c]) begin
          flush_run[c]++;
          check($sformatf("ch%0d_no_valid_in_flush", c), bus.out_valid[c], 0);
        end
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int c = 0; c < NUM_CH; c++) begin
      check($sformatf("%s_ch%0d_valid", tag, c), bus.out_valid[c], 0);
      check($sformatf("%s_ch%0d_flush", tag, c), bus.out_flush[c], 0);
      check($sformatf("%s_ch%0d_data", tag, c), ch_data(c), c);
`ifdef PRODUCER_STALL_CNT_EN
      check($sformatf("%s_ch%0d_stall_cnt", tag, c), bus.stall_cnt[c*16 +: 16], 0);
`endif
    end
    check($sformatf("%s_busy", tag), bus.out_busy, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.enable   = 1'b0;
    bus.in_stall = '0;
    reset        = 1'b1;
    for (int c = 0; c < NUM_CH; c++) flush_run[c] = 0;

    // Reset, then idle with enable low.
    repeat (2) cycle();
    reset = 1'b0;
    repeat (5) cycle();
    check_reset_state("idle");

    // Free run with one 3-cycle stall on ch0 data 5, through the 255->256 flush.
    push_run(0, 0, 300, 1'b1);
    push_run(1, 1, 320, 1'b1);
    bus.enable = 1'b1;
    stall_done = 0;
    for (int i = 0; i < 1000 && exp_q[0].size() != 0; i++) begin
      bus.in_stall[0] = bus.out_valid[0] && (ch_data(0) == 5) && (stall_done < 3);
      if (bus.in_stall[0]) stall_done++;
      cycle();
      if (i == 3) check("busy_running", bus.out_busy, 1);
    end
    bus.in_stall = '0;
    check("runA_ch0_drained", exp_q[0].size(), 0);
    check("runA_stall_cycles", stall_done, 3);

    // Enable dropped while both channels are stalled (ch0 on 9).
    reset      = 1'b1;
    bus.enable = 1'b0;
    repeat (2) cycle();
    reset = 1'b0;
    cycle();
    push_run(0, 0, 9, 1'b1);
    push_run(0, 10, 12, 1'b1);
    push_run(1, 1, 10, 1'b1);
    push_run(1, 11, 13, 1'b1);
    bus.enable = 1'b1;
    for (int i = 0; i < 50 && !(bus.out_valid[0] && ch_data(0) == 9); i++) cycle();
    check("ch0_on_9", ch_data(0), 9);
    check("ch1_on_10", ch_data(1), 10);
    bus.in_stall = '1;
    cycle();
    bus.enable = 1'b0;
    cycle();
    cycle();
    bus.in_stall = '0;
    cycle();
    check("after_drop_valid", bus.out_valid, 0);
    cycle();
    cycle();
    check("after_drop_flush", bus.out_flush, 0);
    check("after_drop_busy", bus.out_busy, 0);
    bus.enable = 1'b1;
    for (int i = 0; i < 20 && exp_q[0].size() != 0; i++) cycle();
    check("reenable_ch0_drained", exp_q[0].size(), 0);
    check("reenable_ch1_drained", exp_q[1].size(), 0);

    // Reset in the middle of a stalled beat.
    bus.in_stall = '1;
    cycle();
    reset = 1'b1;
    cycle();
    check_reset_state("reset_mid_stall");

    // Reset in the middle of a flush window.
    reset        = 1'b0;
    bus.in_stall = '0;
    bus.enable   = 1'b1;
    cycle();
    check("flush_window_open", bus.out_flush, {NUM_CH{1'b1}});
    reset = 1'b1;
    cycle();
    check_reset_state("reset_mid_flush");

`ifdef PRODUCER_STALL_CNT_EN
    // Stall counters saturate and clear only on reset.
    reset = 1'b0;
    push_run(0, 0, 0, 1'b1);
    push_run(1, 1, 1, 1'b1);
    for (int i = 0; i < 10 && !bus.out_valid[0]; i++) cycle();
    bus.in_stall = '1;
    repeat (65540) cycle();
    for (int c = 0; c < NUM_CH; c++)
      check($sformatf("ch%0d_stall_cnt_sat", c), bus.stall_cnt[c*16 +: 16], 16'hFFFF);
    reset = 1'b1;
    cycle();
    check_reset_state("reset_after_sat");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
